// File: rtl/parking_pkg.sv
// Shared definitions for the parking-spot sensing blocks.
// Holds the scan FSM state encoding, the raw distance width and the
// default timing/threshold constants. The display and gate blocks use
// the same constants so they agree on what "occupied" means.
package parking_pkg;

  // Raw echo count width produced by the ranging engine
  localparam int DIST_W = 22;

  // About 100 cm at 100 MHz; below this a spot is occupied
  localparam logic [DIST_W-1:0] OCC_THRESH_DEFAULT = 22'd580_000;
  // About 10 cm release band above the occupy threshold
  localparam logic [DIST_W-1:0] HYST_DEFAULT       = 22'd58_000;
  // 60 ms ring-down between pings at 100 MHz
  localparam int GUARD_CYC_DEFAULT   = 6_000_000;
  // 30 ms worst case from measure pulse to engine ready
  localparam int TIMEOUT_CYC_DEFAULT = 3_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARMED,
    ST_RUN,
    ST_EVAL,
    ST_FAULT,
    ST_GUARD
  } scan_state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for asynchronous sensor echo pins.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   d     - asynchronous input bits
//   q     - synchronised output bits (two clocks of latency)
module echo_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      // stage 0: capture, may go metastable
      meta_p0 <= d;
      // stage 1: resolved copy
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/parking_scan_ctrl.sv
// Round-robin scan controller sharing one ultrasonic ranging engine
// across N_SPOTS HC-SR04 sensors. Sequences trigger, echo capture,
// timeout recovery and guard time, and turns each raw echo count into
// a per-spot occupied bit with hysteresis plus a free-spot count.
// Ports:
//   clk, rst_n       - 100 MHz clock, asynchronous active-low reset
//   en               - scanning enable (checked between measurements)
//   echo_in          - raw asynchronous echo pins, one per spot
//   trig_out         - trigger pins; only the scheduled spot follows eng_trig
//   eng_measure      - one-cycle start pulse to the engine
//   eng_ready        - engine idle flag
//   eng_dist         - engine raw echo count
//   eng_trig         - engine trigger output
//   eng_echo         - synchronised echo of the scheduled spot to the engine
//   eng_rst          - one-cycle engine reset pulse after a timeout
//   cur_spot         - spot currently scheduled
//   occupied, fault  - per-spot occupancy and sticky timeout flags
//   free_count       - N_SPOTS minus number of occupied spots
//   scan_done        - one-cycle pulse when the sweep wraps to spot 0
module parking_scan_ctrl
  import parking_pkg::*;
#(
  parameter int                N_SPOTS     = 4,
  parameter int                SPOT_W      = 2,
  parameter int                GUARD_CYC   = GUARD_CYC_DEFAULT,
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter logic [DIST_W-1:0] OCC_THRESH  = OCC_THRESH_DEFAULT,
  parameter logic [DIST_W-1:0] HYST        = HYST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_SPOTS-1:0] echo_in,
  output logic [N_SPOTS-1:0] trig_out,
  output logic               eng_measure,
  input  logic               eng_ready,
  input  logic [DIST_W-1:0]  eng_dist,
  input  logic               eng_trig,
  output logic               eng_echo,
  output logic               eng_rst,
  output logic [SPOT_W-1:0]  cur_spot,
  output logic [N_SPOTS-1:0] occupied,
  output logic [N_SPOTS-1:0] fault,
  output logic [SPOT_W:0]    free_count,
  output logic               scan_done
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GRD_W = $clog2(GUARD_CYC + 1);
  localparam int CNT_W = SPOT_W + 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(GUARD_CYC - 1);
  localparam logic [SPOT_W-1:0] LAST_SPOT = SPOT_W'(N_SPOTS - 1);

  // Compare in DIST_W+1 bits so threshold + hysteresis cannot wrap
  localparam logic [DIST_W:0] THRESH_X  = {1'b0, OCC_THRESH};
  localparam logic [DIST_W:0] RELEASE_X = {1'b0, OCC_THRESH} + {1'b0, HYST};

  scan_state_t        state;
  logic [TMR_W-1:0]   timer;
  logic [GRD_W-1:0]   guard_cnt;
  logic [N_SPOTS-1:0] echo_s;
  logic [DIST_W:0]    dist_x;
  logic [CNT_W-1:0]   occ_cnt;

  echo_sync #(
    .W (N_SPOTS)
  ) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo_in),
    .q     (echo_s)
  );

  assign dist_x = {1'b0, eng_dist};

  // Only the scheduled sensor sees the engine trigger
  always_comb begin
    trig_out           = '0;
    trig_out[cur_spot] = eng_trig;
  end

  // Echo is gated so stray ring-down never reaches an idle engine
  always_comb begin
    eng_echo = 1'b0;
    if (state == ST_ARMED || state == ST_RUN) begin
      eng_echo = echo_s[cur_spot];
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      occ_cnt = occ_cnt + CNT_W'(occupied[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_count <= CNT_W'(N_SPOTS);
    end else begin
      free_count <= CNT_W'(N_SPOTS) - occ_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      guard_cnt   <= '0;
      cur_spot    <= '0;
      occupied    <= '0;
      fault       <= '0;
      eng_measure <= 1'b0;
      eng_rst     <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      eng_measure <= 1'b0;
      eng_rst     <= 1'b0;
      scan_done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en && eng_ready) begin
            state       <= ST_START;
            eng_measure <= 1'b1;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_ARMED;
        end
        ST_ARMED, ST_RUN: begin
          // Timeout wins over a same-cycle ready edge
          if (timer == TMR_LAST) begin
            state   <= ST_FAULT;
            eng_rst <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
            if (state == ST_ARMED && !eng_ready) begin
              state <= ST_RUN;
            end else if (state == ST_RUN && eng_ready) begin
              state <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          // Between THRESH and THRESH+HYST the previous decision holds
          if (dist_x < THRESH_X) begin
            occupied[cur_spot] <= 1'b1;
          end else if (dist_x > RELEASE_X) begin
            occupied[cur_spot] <= 1'b0;
          end
          fault[cur_spot] <= 1'b0;
          guard_cnt       <= '0;
          state           <= ST_GUARD;
        end
        ST_FAULT: begin
          fault[cur_spot] <= 1'b1;
          guard_cnt       <= '0;
          state           <= ST_GUARD;
        end
        ST_GUARD: begin
          if (guard_cnt == GRD_LAST) begin
            if (cur_spot == LAST_SPOT) begin
              cur_spot  <= '0;
              scan_done <= 1'b1;
            end else begin
              cur_spot <= cur_spot + 1'b1;
            end
            // en is only honoured here, so a started measurement always completes
            if (en) begin
              state       <= ST_START;
              eng_measure <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_scan_ctrl.sv
// Self-checking bench for parking_scan_ctrl with a behavioural ranging
// engine (ten_us = 5 cycles) and behavioural sensors. Each sensor echo
// width is taken from a stimulus queue; the expected occupancy/fault
// state is pushed to a scoreboard when the echo is driven and compared
// whenever cur_spot advances.
module tb_parking_scan_ctrl;

  localparam int N        = 4;
  localparam int SW       = 2;
  localparam int GUARD    = 20;
  localparam int TMO      = 200;
  localparam int THR      = 100;
  localparam int HYS      = 20;
  localparam int TEN_US   = 5;
  localparam int ECHO_DLY = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  echo_in;
  logic [N-1:0]  trig_out;
  logic          eng_measure;
  logic          eng_ready;
  logic [21:0]   eng_dist;
  logic          eng_trig;
  logic          eng_echo;
  logic          eng_rst;
  logic [SW-1:0] cur_spot;
  logic [N-1:0]  occupied;
  logic [N-1:0]  fault;
  logic [SW:0]   free_count;
  logic          scan_done;

  parking_scan_ctrl #(
    .N_SPOTS     (N),
    .SPOT_W      (SW),
    .GUARD_CYC   (GUARD),
    .TIMEOUT_CYC (TMO),
    .OCC_THRESH  (22'(THR)),
    .HYST        (22'(HYS))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .eng_measure (eng_measure),
    .eng_ready   (eng_ready),
    .eng_dist    (eng_dist),
    .eng_trig    (eng_trig),
    .eng_echo    (eng_echo),
    .eng_rst     (eng_rst),
    .cur_spot    (cur_spot),
    .occupied    (occupied),
    .fault       (fault),
    .free_count  (free_count),
    .scan_done   (scan_done)
  );

  typedef struct {
    int spot;
    int width;
  } stim_t;

  typedef struct {
    int           spot;
    logic [N-1:0] occ;
    logic [N-1:0] flt;
    int           free;
  } exp_t;

  stim_t        stim_q[$];
  exp_t         sb_q[$];
  logic [N-1:0] occ_m;
  logic [N-1:0] flt_m;

  int    n_checks = 0;
  int    n_pass   = 0;
  longint cyc     = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Behavioural ranging engine: trigger for TEN_US cycles, then count echo-high cycles
  typedef enum {E_IDLE, E_TRIG, E_WAIT, E_CNT} est_t;
  est_t est;
  int   tcnt;
  int   ecnt;

  initial begin
    eng_ready = 1'b1;
    eng_trig  = 1'b0;
    eng_dist  = '0;
    est       = E_IDLE;
    tcnt      = 0;
    ecnt      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || eng_rst) begin
        eng_ready = 1'b1;
        eng_trig  = 1'b0;
        est       = E_IDLE;
      end else begin
        case (est)
          E_IDLE: if (eng_measure) begin
            eng_ready = 1'b0;
            eng_trig  = 1'b1;
            tcnt      = 1;
            est       = E_TRIG;
          end
          E_TRIG: begin
            if (tcnt == TEN_US) begin
              eng_trig = 1'b0;
              est      = E_WAIT;
            end else begin
              tcnt++;
            end
          end
          E_WAIT: if (eng_echo) begin
            ecnt = 1;
            est  = E_CNT;
          end
          E_CNT: begin
            if (eng_echo) begin
              ecnt++;
            end else begin
              eng_dist  = 22'(ecnt);
              eng_ready = 1'b1;
              est       = E_IDLE;
            end
          end
          default: est = E_IDLE;
        endcase
      end
    end
  end

  // Sensors: after a trigger falls, wait ECHO_DLY then hold echo high for width cycles
  logic [N-1:0] prev_trig;
  int           s_spot;
  int           s_dly;
  int           s_w;
  bit           s_act;

  function automatic void model_update(input int s, input int w);
    if (w == 0) begin
      flt_m[s] = 1'b1;
    end else begin
      if (w < THR) occ_m[s] = 1'b1;
      else if (w > THR + HYS) occ_m[s] = 1'b0;
      flt_m[s] = 1'b0;
    end
  endfunction

  task automatic start_echo(input int i);
    stim_t st;
    exp_t  e;
    if (stim_q.size() == 0) begin
      chk("stim_underrun", stim_q.size(), 1);
    end else begin
      st = stim_q.pop_front();
      chk("stim_spot", i, st.spot);
      model_update(i, st.width);
      e.spot = i;
      e.occ  = occ_m;
      e.flt  = flt_m;
      e.free = N - $countones(occ_m);
      sb_q.push_back(e);
      s_spot = i;
      s_dly  = ECHO_DLY;
      s_w    = st.width;
      s_act  = (st.width != 0);
    end
  endtask

  initial begin
    echo_in   = '0;
    prev_trig = '0;
    s_act     = 1'b0;
    s_spot    = 0;
    s_dly     = 0;
    s_w       = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        echo_in   = '0;
        prev_trig = '0;
        s_act     = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (prev_trig[i] && !trig_out[i]) start_echo(i);
        end
        prev_trig = trig_out;
        if (s_act) begin
          if (s_dly != 0) begin
            s_dly--;
          end else if (s_w != 0) begin
            echo_in[s_spot] = 1'b1;
            s_w--;
          end else begin
            echo_in[s_spot] = 1'b0;
            s_act = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor and scoreboard checker
  int            adv_cnt   = 0;
  int            meas_cnt  = 0;
  int            rst_cnt   = 0;
  int            sd_cnt    = 0;
  int            rst_len   = 0;
  longint        meas_cyc  = 0;
  longint        rst_cyc   = 0;
  int            meas_spot = 0;
  bit            after_fault = 1'b0;
  bit            seen_trig = 1'b0;
  logic [N-1:0]  first_trig = '0;
  logic [SW-1:0] prev_spot = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_spot   = '0;
        rst_len     = 0;
        after_fault = 1'b0;
      end else begin
        if (!seen_trig && trig_out != '0) begin
          seen_trig  = 1'b1;
          first_trig = trig_out;
        end
        if (eng_measure) begin
          meas_cnt++;
          meas_cyc  = cyc;
          meas_spot = int'(cur_spot);
          if (after_fault) begin
            chk("guard_after_fault", cyc - rst_cyc, GUARD + 1);
            chk("spot_after_fault", cur_spot, 2);
            after_fault = 1'b0;
          end
        end
        if (eng_rst) begin
          if (rst_len == 0) begin
            rst_cnt++;
            rst_cyc = cyc;
            // cycles spent timing in ARMED/RUN after the measure pulse
            chk("timeout_len", cyc - meas_cyc - 1, TMO);
            after_fault = 1'b1;
          end
          rst_len++;
        end else if (rst_len != 0) begin
          chk("eng_rst_width", rst_len, 1);
          rst_len = 0;
        end
        if (scan_done) begin
          sd_cnt++;
          chk("scan_done_spot", cur_spot, 0);
        end
        if (cur_spot != prev_spot) begin
          adv_cnt++;
          if (sb_q.size() == 0) begin
            chk("sb_underrun", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            chk("sb_spot", prev_spot, e.spot);
            chk("sb_occupied", occupied, e.occ);
            chk("sb_fault", fault, e.flt);
            chk("sb_free_count", free_count, e.free);
          end
          prev_spot = cur_spot;
        end
      end
    end
  end

  task automatic wait_adv(input int target);
    int budget;
    budget = 400 * (target - adv_cnt) + 400;
    while (adv_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_advance", adv_cnt, target);
  endtask

  task automatic wait_meas(input int target);
    int budget;
    budget = 1000;
    while (meas_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_measure", meas_cnt, target);
  endtask

  task automatic wait_echo(input string tag);
    int budget;
    budget = 1000;
    while (!eng_echo && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, eng_echo, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Ten sweeps, echo widths for spots 0..3 (width == dist; 0 = no echo)
  int sweeps [10][4] = '{
    '{50, 150, 110, 90},
    '{50, 150,  50, 90},
    '{50, 150, 110, 90},
    '{50, 150, 120, 90},
    '{50, 150, 121, 90},
    '{50, 150, 100, 90},
    '{50, 150,  99, 90},
    '{50,  50,  99, 90},
    '{50,   0,  99, 90},
    '{50, 150,  99, 90}
  };
  bit hyst_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic any_meas;
    int   m0;
    int   t;
    occ_m    = '0;
    flt_m    = '0;
    rst_n    = 1'b0;
    en       = 1'b1;
    any_meas = 1'b0;
    for (int s = 0; s < 10; s++) begin
      for (int p = 0; p < N; p++) stim_q.push_back('{p, sweeps[s][p]});
    end
    // spot 0 measured while en drops, then spots 1 and 2 after resuming
    stim_q.push_back('{0, 150});
    stim_q.push_back('{1, 150});
    stim_q.push_back('{2, 99});

    repeat (5) begin
      @(negedge clk);
      any_meas = any_meas | eng_measure;
    end
    chk("reset_measure", any_meas, 0);
    chk("reset_occupied", occupied, 0);
    chk("reset_fault", fault, 0);
    chk("reset_free_count", free_count, 4);
    chk("reset_cur_spot", cur_spot, 0);
    chk("reset_scan_done", scan_done, 0);
    chk("reset_eng_rst", eng_rst, 0);
    rst_n = 1'b1;

    wait_adv(4);
    chk("first_trig", first_trig, 4'b0001);
    chk("sweep_occupied", occupied, 4'b1001);
    chk("sweep_free_count", free_count, 2);
    chk("sweep_scan_done_cnt", sd_cnt, 1);
    chk("sweep_cur_spot", cur_spot, 0);

    for (int k = 2; k <= 7; k++) begin
      wait_adv(4 * k);
      chk("hyst_spot2", occupied[2], hyst_exp[k-2]);
    end

    wait_adv(32);
    chk("pre_timeout_occ", occupied, 4'b1111);
    wait_adv(36);
    chk("timeout_fault", fault, 4'b0010);
    chk("timeout_occ_held", occupied, 4'b1111);
    chk("timeout_rst_cnt", rst_cnt, 1);
    wait_adv(40);
    chk("fault_cleared", fault, 4'b0000);
    chk("post_timeout_occ", occupied, 4'b1101);

    // Drop en while spot 0 is echoing; the measurement must still land
    wait_echo("en_drop_echo");
    en = 1'b0;
    wait_adv(41);
    m0 = meas_cnt;
    repeat (300) @(negedge clk);
    chk("idle_no_measure", meas_cnt, m0);
    chk("idle_cur_spot", cur_spot, 1);
    chk("idle_occupied", occupied, 4'b1100);
    chk("idle_free_count", free_count, 2);
    en = 1'b1;
    wait_meas(m0 + 1);
    chk("resume_spot", meas_spot, 1);
    wait_adv(42);

    // Reset while spot 2 echo is high
    wait_echo("reset_echo");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_occupied", occupied, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_free_count", free_count, 4);
    chk("midrst_cur_spot", cur_spot, 0);
    chk("midrst_eng_echo", eng_echo, 0);
    chk("midrst_eng_measure", eng_measure, 0);
    sb_q.delete();
    occ_m = '0;
    flt_m = '0;
    stim_q.push_back('{0, 50});
    m0 = meas_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_meas(m0 + 1);
    chk("restart_spot", meas_spot, 0);
    en = 1'b0;
    t = adv_cnt + 1;
    wait_adv(t);
    chk("restart_occupied", occupied, 4'b0001);
    chk("restart_free_count", free_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_scan_ctrl.md
Name: parking_scan_ctrl

Overview:
Round-robin scheduler that time-shares one ultrasonic ranging engine (measure/ready/22-bit raw distance) across N_SPOTS HC-SR04 sensors, one per parking spot. It sequences trigger, echo capture, timeout recovery and the inter-ping guard time. It converts each raw echo count into a per-spot occupied bit with hysteresis, and maintains a free-spot count for the display and gate logic.

Parameters:
N_SPOTS, 4, number of sensors/spots (2..16)
SPOT_W, 2, index width, equal to clog2(N_SPOTS)
GUARD_CYC, 6_000_000, idle cycles between pings (60 ms at 100 MHz) for echo ring-down
TIMEOUT_CYC, 3_000_000, maximum cycles from measure pulse to engine ready
OCC_THRESH, 22'd580_000, raw count below which a spot is occupied (about 100 cm)
HYST, 22'd58_000, release band above OCC_THRESH (about 10 cm)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous reset, active low
en  in  1  scanning enable
echo_in  in  N_SPOTS  raw sensor echo pins, asynchronous
trig_out  out  N_SPOTS  sensor trigger pins
eng_measure  out  1  one-cycle start pulse to the engine
eng_ready  in  1  engine idle flag
eng_dist  in  22  engine raw echo count
eng_trig  in  1  engine trigger output
eng_echo  out  1  muxed, synchronised echo to the engine
eng_rst  out  1  one-cycle engine reset pulse (active high); top level drives engine rst = ~rst_n | eng_rst
cur_spot  out  SPOT_W  spot currently scheduled
occupied  out  N_SPOTS  per-spot occupancy
fault  out  N_SPOTS  per-spot sticky timeout flag
free_count  out  SPOT_W+1  N_SPOTS minus popcount(occupied)
scan_done  out  1  one-cycle pulse when a full sweep completes

Behaviour:
- Reset values: occupied=0, fault=0, free_count=N_SPOTS, cur_spot=0, eng_measure=0, eng_rst=0, scan_done=0, FSM=IDLE. Asserting rst_n low mid-operation aborts immediately.
- Echo path: 2-flop synchroniser per echo_in bit.
  - eng_echo = synced echo_in[cur_spot] in ARMED/RUN only, otherwise 0.
  - trig_out[i] = eng_trig when i==cur_spot, otherwise 0 (combinational).
- FSM states:
  - IDLE: if en and eng_ready, go to START.
  - START: eng_measure=1 for exactly one cycle; clear the timer; go to ARMED.
  - ARMED: wait for eng_ready==0, then go to RUN.
  - RUN: wait for eng_ready==1, then go to EVAL.
  - Timeout: the timer counts in ARMED and RUN. When timer==TIMEOUT_CYC-1, go to FAULT. A timeout takes priority over eng_ready rising in the same cycle.
  - FAULT: eng_rst=1 for one cycle; fault[cur_spot]<=1; occupied unchanged; go to GUARD.
  - EVAL: sample eng_dist (zero-extend to 23 bits).
    - dist < OCC_THRESH: occupied[cur_spot]<=1.
    - dist > OCC_THRESH+HYST: occupied[cur_spot]<=0.
    - Otherwise hold.
    - Clear fault[cur_spot]; go to GUARD.
    - Boundaries: dist==OCC_THRESH holds or releases (not set); dist==OCC_THRESH+HYST holds.
  - GUARD: count GUARD_CYC cycles. On the last cycle:
    - cur_spot advances, wrapping N_SPOTS-1 to 0.
    - scan_done pulses in the same cycle as the wrap.
    - If en is high, go to START; otherwise go to IDLE.
- en low during START..GUARD does not abort: the measurement completes, then the FSM stops after GUARD. cur_spot is retained while IDLE.
- free_count is registered and updates the cycle after any occupied change.
- Latency: measure pulse occurs 1 cycle after leaving IDLE; occupied updates 1 cycle after eng_ready returns high.

Decomposition:
- Shared package parking_pkg holds:
  - FSM state encoding (IDLE, START, ARMED, RUN, EVAL, FAULT, GUARD);
  - distance/threshold width (22);
  - default OCC_THRESH, HYST, GUARD_CYC and TIMEOUT_CYC constants, also used by the display/gate blocks.
- One sub-module, echo_sync: a parameterised-width 2-flop synchroniser with asynchronous active-low reset to 0.

Test Plan:
Common bench settings: N_SPOTS=4, GUARD_CYC=20, TIMEOUT_CYC=200, OCC_THRESH=100, HYST=20, real engine with ten_us=5.
- Reset: pulse rst_n low with en=1 -> occupied=0, fault=0, free_count=4, no eng_measure until rst_n high; first trig_out pulse on bit 0 only.
- Sweep: echo widths giving dist 50/150/110/90 on spots 0..3 -> occupied=4'b1001, free_count=2, exactly one scan_done pulse after spot 3 GUARD, cur_spot back to 0.
- Hysteresis on spot 2: 50 -> 1; 110 -> stays 1; 120 -> stays 1; 121 -> 0; 100 -> stays 0; 99 -> 1.
- Timeout: spot 1 echo never rises -> eng_rst high exactly 1 cycle 200 cycles after eng_measure, fault[1]=1, occupied[1] unchanged, spot 2 triggered after 20 guard cycles. A later valid spot-1 reading clears fault[1].
- en drop: deassert en during RUN -> EVAL updates occupancy, GUARD completes, FSM reaches IDLE, no further eng_measure; re-asserting en resumes at the next spot.
- Mid-measure reset: assert rst_n low in RUN with echo high -> outputs return to reset values in the same cycle, eng_echo=0, scan restarts at spot 0.
